// File: rtl/hist_eq_lut_mapper.sv
// rtl/hist_eq_lut_mapper.sv - histogram-equalization LUT builder and pixel remapper
module hist_eq_lut_mapper #(
  parameter int PIX_LOG2    = 8,
  parameter int HIST_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  hist_addr,
  input  logic [15:0] hist_data,
  input  logic [7:0]  in_pixel,
  input  logic        in_valid,
  input  logic        in_hs,
  input  logic        in_vs,
  output logic [7:0]  out_pixel,
  output logic        out_valid,
  output logic        out_hs,
  output logic        out_vs,
  output logic        lut_valid
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [23:0] cdf_q, cdf_d;

  // Read-latency tracking: which bin the arriving hist_data belongs to.
  logic [HIST_RD_LAT-1:0] rd_v_q;
  logic [7:0]             rd_idx_q [HIST_RD_LAT];
  logic                   cap;
  logic [7:0]             cap_idx;

  logic [23:0] cdf_next;
  logic [31:0] prod;
  logic [31:0] norm;
  logic [7:0]  lut_entry;

  // Two 256-entry banks; the top address bit selects the bank.
  logic [7:0]  lut_mem [512];
  logic        bank_q, swap_pending_q, lut_valid_q;
  logic        vs_rise, swap;

  logic        v1_q, hs1_q, vs1_q, lv1_q;
  logic [7:0]  pix1_q, rd_data_q;
  logic        out_valid_q, out_hs_q, out_vs_q;
  logic [7:0]  out_pixel_q;

  assign cap     = rd_v_q[HIST_RD_LAT-1];
  assign cap_idx = rd_idx_q[HIST_RD_LAT-1];

  // Inclusive CDF and its normalized, clamped LUT entry.
  always_comb begin
    cdf_next  = cdf_q + {8'd0, hist_data};
    prod      = {8'd0, cdf_next} * 32'd255;
    norm      = prod >> PIX_LOG2;
    lut_entry = (norm > 32'd255) ? 8'hFF : norm[7:0];
  end

  // Build FSM next-state and status outputs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cdf_d   = cdf_q;
    busy    = 1'b0;
    done    = 1'b0;
    if (cap) cdf_d = cdf_next;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          addr_d  = 8'd0;
          cdf_d   = 24'd0;
        end
      end
      SCAN: begin
        busy   = 1'b1;
        addr_d = addr_q + 8'd1;
        if (addr_q == 8'hFF) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (cap && cap_idx == 8'hFF) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, address and CDF registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= 8'd0;
      cdf_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cdf_q   <= cdf_d;
    end
  end

  // Valid flag follows each issued address through the read latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_v_q <= '0;
    end else begin
      rd_v_q[0] <= (state_q == SCAN);
      for (int i = 1; i < HIST_RD_LAT; i++) rd_v_q[i] <= rd_v_q[i-1];
    end
  end

  // Bin index travelling alongside the valid flag.
  always_ff @(posedge clk) begin
    rd_idx_q[0] <= addr_q;
    for (int i = 1; i < HIST_RD_LAT; i++) rd_idx_q[i] <= rd_idx_q[i-1];
  end

  // LUT RAM: build writes the inactive bank, pixel path reads the active one.
  always_ff @(posedge clk) begin
    if (cap) lut_mem[{~bank_q, cap_idx}] <= lut_entry;
    rd_data_q <= lut_mem[{bank_q, in_pixel}];
  end

  assign vs_rise = in_vs & ~vs1_q;
  assign swap    = vs_rise & (swap_pending_q | (state_q == FIN));

  // Bank swap happens only on a vsync rise once a table is finished.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_q         <= 1'b0;
      swap_pending_q <= 1'b0;
      lut_valid_q    <= 1'b0;
    end else if (swap) begin
      bank_q         <= ~bank_q;
      swap_pending_q <= 1'b0;
      lut_valid_q    <= 1'b1;
    end else if (state_q == FIN) begin
      swap_pending_q <= 1'b1;
    end
  end

  // Two-stage pixel path; lut_valid is pipelined with the RAM read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q        <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      lv1_q       <= 1'b0;
      pix1_q      <= 8'd0;
      out_valid_q <= 1'b0;
      out_hs_q    <= 1'b0;
      out_vs_q    <= 1'b0;
      out_pixel_q <= 8'd0;
    end else begin
      v1_q        <= in_valid;
      hs1_q       <= in_hs;
      vs1_q       <= in_vs;
      lv1_q       <= lut_valid_q;
      pix1_q      <= in_pixel;
      out_valid_q <= v1_q;
      out_hs_q    <= hs1_q;
      out_vs_q    <= vs1_q;
      if (v1_q) out_pixel_q <= lv1_q ? rd_data_q : pix1_q;
    end
  end

  assign hist_addr = addr_q;
  assign out_pixel = out_pixel_q;
  assign out_valid = out_valid_q;
  assign out_hs    = out_hs_q;
  assign out_vs    = out_vs_q;
  assign lut_valid = lut_valid_q;

endmodule

// File: tb/tb_hist_eq_lut_mapper.sv
// tb/tb_hist_eq_lut_mapper.sv - self-checking bench for hist_eq_lut_mapper
module tb_hist_eq_lut_mapper;

  localparam int PIX_LOG2 = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_pixel;
  logic        in_valid, in_hs, in_vs;

  logic        busy_w [2];
  logic        done_w [2];
  logic [7:0]  hist_addr_w [2];
  logic [15:0] hist_data_w [2];
  logic [7:0]  out_pixel_w [2];
  logic        out_valid_w [2];
  logic        out_hs_w [2];
  logic        out_vs_w [2];
  logic        lut_valid_w [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hist_eq_lut_mapper #(.PIX_LOG2(PIX_LOG2), .HIST_RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy_w[0]), .done(done_w[0]),
    .hist_addr(hist_addr_w[0]), .hist_data(hist_data_w[0]),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_hs(in_hs), .in_vs(in_vs),
    .out_pixel(out_pixel_w[0]), .out_valid(out_valid_w[0]), .out_hs(out_hs_w[0]),
    .out_vs(out_vs_w[0]), .lut_valid(lut_valid_w[0]));

  hist_eq_lut_mapper #(.PIX_LOG2(PIX_LOG2), .HIST_RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .busy(busy_w[1]), .done(done_w[1]),
    .hist_addr(hist_addr_w[1]), .hist_data(hist_data_w[1]),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_hs(in_hs), .in_vs(in_vs),
    .out_pixel(out_pixel_w[1]), .out_valid(out_valid_w[1]), .out_hs(out_hs_w[1]),
    .out_vs(out_vs_w[1]), .lut_valid(lut_valid_w[1]));

  // Histogram memory with read latency 1 (dut) and 3 (dut3).
  logic [15:0] hist_mem [256];
  logic [15:0] hp1, h3a, h3b, h3c;
  always @(posedge clk) begin
    hp1 <= hist_mem[hist_addr_w[0]];
    h3a <= hist_mem[hist_addr_w[1]];
    h3b <= h3a;
    h3c <= h3b;
  end
  assign hist_data_w[0] = hp1;
  assign hist_data_w[1] = h3c;

  function automatic int lat(input int j);
    return (j == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input int j, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, j, act, exp, $time);
    end
  endtask

  // Reference table straight from the equalization formula.
  logic [7:0] ref_tbl [256];
  task automatic compute_ref();
    longint cdf;
    longint v;
    cdf = 0;
    for (int i = 0; i < 256; i++) begin
      cdf = cdf + longint'(hist_mem[i]);
      v = (cdf * 255) >> PIX_LOG2;
      ref_tbl[i] = (v > 255) ? 8'hFF : v[7:0];
    end
  endtask

  // Behavioural model state per instance.
  logic       m_build [2];
  int         m_k [2];
  logic       m_pend [2];
  logic       m_lv [2];
  logic       m_vs_prev [2];
  logic [7:0] act_tbl [2][256];
  logic [7:0] pend_tbl [2][256];
  logic       s1_v [2], s1_hs [2], s1_vs [2];
  logic [7:0] s1_pix [2];
  logic       e_v [2], e_hs [2], e_vs [2];
  logic [7:0] e_pix [2];

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (!rst) begin
        m_build[j] = 1'b0; m_k[j] = 0; m_pend[j] = 1'b0; m_lv[j] = 1'b0;
        m_vs_prev[j] = 1'b0;
        s1_v[j] = 1'b0; s1_hs[j] = 1'b0; s1_vs[j] = 1'b0; s1_pix[j] = 8'd0;
        e_v[j] = 1'b0; e_hs[j] = 1'b0; e_vs[j] = 1'b0; e_pix[j] = 8'd0;
      end else begin
        logic fin, rise;
        logic [7:0] mapped;
        fin    = m_build[j] && (m_k[j] == 257 + lat(j));
        rise   = in_vs && !m_vs_prev[j];
        mapped = m_lv[j] ? act_tbl[j][in_pixel] : in_pixel;
        e_v[j] = s1_v[j]; e_hs[j] = s1_hs[j]; e_vs[j] = s1_vs[j];
        if (s1_v[j]) e_pix[j] = s1_pix[j];
        s1_v[j] = in_valid; s1_hs[j] = in_hs; s1_vs[j] = in_vs; s1_pix[j] = mapped;
        if (fin) begin
          m_build[j] = 1'b0;
          compute_ref();
          for (int i = 0; i < 256; i++) pend_tbl[j][i] = ref_tbl[i];
        end else if (m_build[j]) begin
          m_k[j] = m_k[j] + 1;
        end else if (start) begin
          m_build[j] = 1'b1;
          m_k[j] = 1;
        end
        if ((m_pend[j] || fin) && rise) begin
          for (int i = 0; i < 256; i++) act_tbl[j][i] = pend_tbl[j][i];
          m_lv[j] = 1'b1;
          m_pend[j] = 1'b0;
        end else if (fin) begin
          m_pend[j] = 1'b1;
        end
        m_vs_prev[j] = in_vs;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    for (int j = 0; j < 2; j++) begin
      check("out_pixel", j, int'(out_pixel_w[j]), int'(e_pix[j]));
      check("out_valid", j, int'(out_valid_w[j]), int'(e_v[j]));
      check("out_hs", j, int'(out_hs_w[j]), int'(e_hs[j]));
      check("out_vs", j, int'(out_vs_w[j]), int'(e_vs[j]));
      check("lut_valid", j, int'(lut_valid_w[j]), int'(m_lv[j]));
      check("busy", j, int'(busy_w[j]), (m_build[j] && m_k[j] <= 256 + lat(j)) ? 1 : 0);
      check("done", j, int'(done_w[j]), (m_build[j] && m_k[j] == 257 + lat(j)) ? 1 : 0);
      if (m_build[j] && m_k[j] <= 256)
        check("hist_addr", j, int'(hist_addr_w[j]), m_k[j] - 1);
    end
  end

  task automatic do_build(input bit extra_start, input int abort_at);
    int first_done [2];
    int n_done [2];
    first_done[0] = -1; first_done[1] = -1;
    n_done[0] = 0; n_done[1] = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        if (done_w[j]) begin
          n_done[j]++;
          if (first_done[j] < 0) first_done[j] = k;
        end
      end
      start    = (extra_start && k == 50) ? 1'b1 : 1'b0;
      in_pixel = k[7:0];
      in_valid = k[0];
      in_hs    = k[2];
      if (abort_at == k) rst = 1'b0;
      if (abort_at + 2 == k) rst = 1'b1;
    end
    in_valid = 1'b0;
    in_hs    = 1'b0;
    if (abort_at > 0) begin
      check("abort_no_done", 0, n_done[0], 0);
      check("abort_no_done", 1, n_done[1], 0);
      check("abort_busy", 0, int'(busy_w[0]), 0);
      check("abort_lut_valid", 0, int'(lut_valid_w[0]), 0);
    end else begin
      check("done_count", 0, n_done[0], 1);
      check("done_count", 1, n_done[1], 1);
      check("done_cycle", 0, first_done[0], 258);
      check("done_cycle", 1, first_done[1], 260);
    end
  endtask

  task automatic vs_pulse();
    @(negedge clk); in_vs = 1'b1;
    @(negedge clk); in_vs = 1'b0;
    @(negedge clk);
  endtask

  task automatic px(input logic [7:0] p, input int exp);
    @(negedge clk); in_pixel = p; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    check("px_literal", 0, int'(out_pixel_w[0]), exp);
    check("px_literal", 1, int'(out_pixel_w[1]), exp);
  endtask

  task automatic set_hist(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0: hist_mem[i] = (i == 8'h80) ? 16'd256 : 16'd0;
        1: hist_mem[i] = 16'd1;
        default: hist_mem[i] = (i == 0) ? 16'd512 : 16'd0;
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; start = 1'b0;
    in_pixel = 8'h37; in_valid = 1'b1; in_hs = 1'b0; in_vs = 1'b0;
    set_hist(0);

    // 1: reset values, then identity mapping
    repeat (3) @(negedge clk);
    check("rst_out_pixel", 0, int'(out_pixel_w[0]), 0);
    check("rst_out_valid", 0, int'(out_valid_w[0]), 0);
    check("rst_hist_addr", 0, int'(hist_addr_w[0]), 0);
    check("rst_busy", 0, int'(busy_w[0]), 0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ident_after_rst", 0, int'(out_pixel_w[0]), 8'h37);
    check("ident_after_rst", 1, int'(out_pixel_w[1]), 8'h37);
    in_valid = 1'b0;

    // 2: single spike at 0x80
    compute_ref();
    check("model_pin_7f", 0, int'(ref_tbl[8'h7F]), 0);
    check("model_pin_80", 0, int'(ref_tbl[8'h80]), 255);
    do_build(1'b0, 0);
    vs_pulse();
    check("lut_valid_after_swap", 0, int'(lut_valid_w[0]), 1);
    px(8'h7F, 8'h00);
    px(8'h80, 8'hFF);
    px(8'hFF, 8'hFF);

    // 3: flat histogram
    set_hist(1);
    compute_ref();
    check("model_pin_127", 0, int'(ref_tbl[127]), 127);
    check("model_pin_254", 0, int'(ref_tbl[254]), 254);
    do_build(1'b0, 0);
    vs_pulse();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk); in_pixel = 8'(i); in_valid = 1'b1;
    end
    @(negedge clk); in_valid = 1'b0;
    px(8'd0, 0);
    px(8'd127, 127);
    px(8'd254, 254);
    px(8'd255, 255);

    // 4: everything in bin 0 -> clamp
    set_hist(2);
    compute_ref();
    check("model_pin_clamp", 0, int'(ref_tbl[0]), 255);
    do_build(1'b0, 0);
    vs_pulse();
    px(8'd0, 8'hFF);
    px(8'h80, 8'hFF);
    px(8'hFF, 8'hFF);

    // 5: mid-frame build, old mapping held until vsync rise; extra start ignored
    set_hist(1);
    do_build(1'b1, 0);
    px(8'h10, 8'hFF);
    @(negedge clk); in_vs = 1'b1; in_pixel = 8'h20; in_valid = 1'b1;
    @(negedge clk); in_pixel = 8'h21;
    @(negedge clk); in_valid = 1'b0; in_vs = 1'b0;
    check("swap_rise_cycle_old", 0, int'(out_pixel_w[0]), 8'hFF);
    @(negedge clk);
    check("swap_next_cycle_new", 0, int'(out_pixel_w[0]), 8'h21);
    check("swap_next_cycle_new", 1, int'(out_pixel_w[1]), 8'h21);

    // 6: reset mid-build, then a full build
    set_hist(0);
    do_build(1'b0, 100);
    px(8'h55, 8'h55);
    do_build(1'b0, 0);
    vs_pulse();
    px(8'h7F, 8'h00);
    px(8'h80, 8'hFF);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
